// File: rtl/instr_encoder_loader.sv
// Encodes a mnemonic plus operand fields into a PA-RISC instruction word and writes it big-endian into byte-wide instruction RAM.
// Optional XOR checksum of completed words is built when ENC_CHECKSUM_EN is defined.
module instr_encoder_loader #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64,
  localparam int CNT_W      = $clog2(DEPTH_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_r1,
  input  logic [4:0]        in_r2,
  input  logic [4:0]        in_t,
  input  logic [2:0]        in_cond,
  input  logic [10:0]       in_imm,
  input  logic [11:0]       in_disp,
  input  logic              in_n,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              busy,
  output logic              full,
  output logic [CNT_W-1:0]  word_count,
`ifdef ENC_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              err_bad_op,
  output logic [31:0]       enc_word
);

  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         enc_word_q, enc_word_d;
  logic                err_q, err_d;
  logic [31:0]         ck_q, ck_d;
  logic [31:0]         enc_new;
  logic                legal;
  logic [12:0]         disp_field;
  logic [10:0]         imm_field;

  // Displacement and immediate use the low-sign-extension bit order the decoder expects.
  always_comb begin
    disp_field = {in_disp[9:0], in_disp[10], in_n, in_disp[11]};
    imm_field  = {in_imm[9:0], in_imm[10]};
    legal      = 1'b1;
    enc_new    = 32'h0;
    case (in_mnem)
      4'd0:  enc_new = {6'b000010, in_r2, in_r1, in_cond, 1'b0, 6'b011000, 1'b0, in_t};
      4'd1:  enc_new = {6'b000010, in_r2, in_r1, in_cond, 1'b0, 6'b011100, 1'b0, in_t};
      4'd2:  enc_new = {6'b000010, in_r2, in_r1, in_cond, 1'b0, 6'b101000, 1'b0, in_t};
      4'd3:  enc_new = {6'b000010, in_r2, in_r1, in_cond, 1'b0, 6'b010000, 1'b0, in_t};
      4'd4:  enc_new = {6'b000010, in_r2, in_r1, in_cond, 1'b0, 6'b010100, 1'b0, in_t};
      4'd5:  enc_new = {6'b000010, in_r2, in_r1, in_cond, 1'b0, 6'b001001, 1'b0, in_t};
      4'd6:  enc_new = {6'b000010, in_r2, in_r1, in_cond, 1'b0, 6'b001010, 1'b0, in_t};
      4'd7:  enc_new = {6'b000010, in_r2, in_r1, in_cond, 1'b0, 6'b001000, 1'b0, in_t};
      4'd8:  enc_new = {6'b111010, in_t, 8'b0, disp_field};
      4'd9:  enc_new = {6'b100000, in_r2, in_r1, in_cond, disp_field};
      4'd10: enc_new = {6'b100010, in_r2, in_r1, in_cond, disp_field};
      4'd11: enc_new = {6'b101101, in_r2, in_t, in_cond, 2'b00, imm_field};
      4'd12: enc_new = {6'b100101, in_r2, in_t, in_cond, 2'b00, imm_field};
      4'd13: enc_new = 32'h0;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    full     = (cnt_q == CNT_W'(DEPTH_WORDS));
    in_ready = (state_q == IDLE) && !full;
    busy     = (state_q != IDLE);
    mem_we   = busy;
    mem_addr = '0;
    mem_din  = 8'h0;
    case (state_q)
      WR0: begin mem_addr = ptr_q;               mem_din = enc_word_q[31:24]; end
      WR1: begin mem_addr = ptr_q + ADDR_W'(1);  mem_din = enc_word_q[23:16]; end
      WR2: begin mem_addr = ptr_q + ADDR_W'(2);  mem_din = enc_word_q[15:8];  end
      WR3: begin mem_addr = ptr_q + ADDR_W'(3);  mem_din = enc_word_q[7:0];   end
      default: ;
    endcase
  end

  // restart wins over any pending request and abandons a partially written word.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    enc_word_d = enc_word_q;
    err_d      = 1'b0;
    ck_d       = ck_q;
    if (restart) begin
      state_d = IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      ck_d    = 32'h0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          if (legal) begin
            enc_word_d = enc_new;
            state_d    = WR0;
          end else begin
            err_d = 1'b1;
          end
        end
        WR0: state_d = WR1;
        WR1: state_d = WR2;
        WR2: state_d = WR3;
        WR3: begin
          state_d = IDLE;
          ptr_d   = ptr_q + ADDR_W'(4);
          cnt_d   = cnt_q + CNT_W'(1);
          ck_d    = ck_q ^ enc_word_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      enc_word_q <= 32'h0;
      err_q      <= 1'b0;
      ck_q       <= 32'h0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      enc_word_q <= enc_word_d;
      err_q      <= err_d;
      ck_q       <= ck_d;
    end
  end

  assign word_count = cnt_q;
  assign err_bad_op = err_q;
  assign enc_word   = enc_word_q;
`ifdef ENC_CHECKSUM_EN
  assign checksum   = ck_q;
`else
  logic unused_ck;
  assign unused_ck = ^ck_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed cases plus random requests against an arithmetic encoding model.
// Build with ENC_CHECKSUM_EN defined to also cover the checksum output.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset, restart, in_valid, in_ready, in_n;
  logic [3:0]        in_mnem;
  logic [4:0]        in_r1, in_r2, in_t;
  logic [2:0]        in_cond;
  logic [10:0]       in_imm;
  logic [11:0]       in_disp;
  logic              mem_we, busy, full, err_bad_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [CNT_W-1:0]  word_count;
  logic [31:0]       enc_word;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int checks   = 0;
  int failures = 0;
  int model_ptr, model_count;
  logic [31:0] model_ck, model_last;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_r1(in_r1), .in_r2(in_r2), .in_t(in_t), .in_cond(in_cond),
    .in_imm(in_imm), .in_disp(in_disp), .in_n(in_n), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .busy(busy), .full(full), .word_count(word_count),
`ifdef ENC_CHECKSUM_EN
    .checksum(checksum),
`endif
    .err_bad_op(err_bad_op), .enc_word(enc_word)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Encoding computed field-by-field with shifts from the instruction format tables.
  function automatic logic [31:0] model_encode(input int mnem, input int r1, input int r2, input int t,
                                               input int cond, input int imm, input int disp, input int n,
                                               output bit legal);
    int op2_tbl [8] = '{'h18, 'h1C, 'h28, 'h10, 'h14, 'h09, 'h0A, 'h08};
    int w, immf, dispf;
    immf  = ((imm & 'h3FF) << 1) | ((imm >> 10) & 1);
    dispf = ((disp & 'h3FF) << 3) | (((disp >> 10) & 1) << 2) | ((n & 1) << 1) | ((disp >> 11) & 1);
    legal = 1'b1;
    w = 0;
    if (mnem <= 7)       w = (2 << 26) | (r2 << 21) | (r1 << 16) | (cond << 13) | (op2_tbl[mnem] << 6) | t;
    else if (mnem == 8)  w = ('h3A << 26) | (t << 21) | dispf;
    else if (mnem == 9)  w = ('h20 << 26) | (r2 << 21) | (r1 << 16) | (cond << 13) | dispf;
    else if (mnem == 10) w = ('h22 << 26) | (r2 << 21) | (r1 << 16) | (cond << 13) | dispf;
    else if (mnem == 11) w = ('h2D << 26) | (r2 << 21) | (t << 16) | (cond << 13) | immf;
    else if (mnem == 12) w = ('h25 << 26) | (r2 << 21) | (t << 16) | (cond << 13) | immf;
    else if (mnem == 13) w = 0;
    else legal = 1'b0;
    return 32'(w);
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_word_count"}, 32'(word_count), 32'(model_count));
    checkOutput({tag, "_full"}, 32'(full), 32'(model_count == DEPTH));
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(model_count != DEPTH));
`ifdef ENC_CHECKSUM_EN
    checkOutput({tag, "_checksum"}, checksum, model_ck);
`endif
  endtask

  task automatic applyStimulus(input int mnem, input int r1, input int r2, input int t,
                               input int cond, input int imm, input int disp, input int n);
    logic [31:0] w;
    bit legal;
    w = model_encode(mnem, r1, r2, t, cond, imm, disp, n, legal);
    @(negedge clk);
    in_mnem = 4'(mnem); in_r1 = 5'(r1); in_r2 = 5'(r2); in_t = 5'(t);
    in_cond = 3'(cond); in_imm = 11'(imm); in_disp = 12'(disp); in_n = 1'(n);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (legal) begin
      model_last = w;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'((model_ptr + k) & 'hFF));
        checkOutput("wr_mem_din", 32'(mem_din), (w >> (24 - 8 * k)) & 32'hFF);
        checkOutput("wr_busy", 32'(busy), 32'd1);
        checkOutput("wr_in_ready", 32'(in_ready), 32'd0);
        checkOutput("wr_enc_word", enc_word, w);
      end
      @(negedge clk);
      model_ptr += 4;
      model_count++;
      model_ck ^= w;
      checkIdle("after_word");
    end else begin
      checkOutput("bad_err_pulse", 32'(err_bad_op), 32'd1);
      checkOutput("bad_enc_kept", enc_word, model_last);
      checkIdle("bad_op");
      @(negedge clk);
      checkOutput("bad_err_drop", 32'(err_bad_op), 32'd0);
      checkOutput("bad_no_we", 32'(mem_we), 32'd0);
    end
  endtask

  task automatic pulseRestart(input logic with_valid);
    @(negedge clk);
    restart = 1'b1;
    in_valid = with_valid;
    in_mnem = 4'd0;
    @(negedge clk);
    restart = 1'b0;
    in_valid = 1'b0;
    model_ptr = 0; model_count = 0; model_ck = 32'h0;
    checkIdle("restart");
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; in_mnem = 4'd0;
    in_r1 = '0; in_r2 = '0; in_t = '0; in_cond = '0; in_imm = '0; in_disp = '0; in_n = 1'b0;
    model_ptr = 0; model_count = 0; model_ck = 32'h0; model_last = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_enc_word", enc_word, 32'h0);
    checkOutput("reset_err", 32'(err_bad_op), 32'd0);

    applyStimulus(0, 3, 4, 5, 0, 0, 0, 0);
    checkOutput("add_literal", enc_word, 32'h08830605);
    applyStimulus(11, 0, 1, 2, 0, -1, 0, 0);
    checkOutput("addi_m1_literal", enc_word, 32'hB42207FF);
`ifdef ENC_CHECKSUM_EN
    checkOutput("checksum_literal", checksum, 32'hBCA101FA);
`endif
    applyStimulus(11, 0, 1, 2, 0, 5, 0, 0);
    checkOutput("addi_p5_low", 32'(enc_word[10:0]), 32'h00A);
    applyStimulus(15, 1, 2, 3, 4, 0, 0, 0);
    applyStimulus(8, 0, 0, 7, 0, 0, 12'hABC, 1);

    for (int i = 0; i < 20; i++)
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 1)));

    pulseRestart(1'b1);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(13, int'($urandom_range(0, 31)), 0, 0, 0, 0, 0, 0);
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_mnem = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("full_ignore_we", 32'(mem_we), 32'd0);
      checkOutput("full_count", 32'(word_count), 32'(DEPTH));
    end
    in_valid = 1'b0;
    pulseRestart(1'b0);
    applyStimulus(0, 3, 4, 5, 0, 0, 0, 0);

    pulseRestart(1'b0);
    @(negedge clk);
    in_mnem = 4'd6; in_r1 = 5'd9; in_r2 = 5'd10; in_t = 5'd11; in_cond = 3'd2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("abort_wr0_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    checkOutput("abort_wr1_addr", 32'(mem_addr), 32'd1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checkIdle("abort_wr1");
    applyStimulus(7, 1, 2, 3, 1, 0, 0, 0);

    @(negedge clk);
    in_mnem = 4'd9; in_r1 = 5'd1; in_r2 = 5'd2; in_disp = 12'h7FF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0; model_count = 0; model_ck = 32'h0; model_last = 32'h0;
    checkIdle("reset_mid_word");
    checkOutput("reset_mid_enc", enc_word, 32'h0);
    applyStimulus(2, 31, 30, 29, 7, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
